// File: rtl/log2_approx_pkg.sv
// Shared widths and elaboration helpers for the log2 approximation pipeline.
package log2_approx_pkg;

  localparam int DEF_LANES    = 2;
  localparam int DEF_DW       = 16;
  localparam int DEF_IN_FRAC  = 11;
  localparam int DEF_OUT_INT  = 6;
  localparam int DEF_OUT_FRAC = 10;
  localparam int MAX_OW       = 64;

  // Two's complement width needed to represent the signed value v.
  function automatic int signed_bits(input int v);
    if (v >= 0) return $clog2(v + 1) + 1;
    else        return $clog2(-v) + 1;
  endfunction

  // Integer bits needed for exponents spanning -in_frac .. dw-1-in_frac.
  function automatic int req_out_int(input int dw, input int in_frac);
    int hi_bits;
    int lo_bits;
    hi_bits = signed_bits(dw - 1 - in_frac);
    lo_bits = signed_bits(-in_frac);
    return (hi_bits > lo_bits) ? hi_bits : lo_bits;
  endfunction

  // Most negative OW-bit value, used as the result for a zero input.
  function automatic logic [MAX_OW-1:0] min_result(input int ow);
    return MAX_OW'(1) << (ow - 1);
  endfunction

endpackage

// File: rtl/log2_lzc.sv
// Combinational leading-zero counter; lz is meaningless when all_zero_o is set.
module log2_lzc
  import log2_approx_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int LZW = (DW > 1) ? $clog2(DW) : 1
) (
  input  logic [DW-1:0]  data_i,
  output logic [LZW-1:0] lz_o,
  output logic           all_zero_o
);

  logic found;

  always_comb begin
    lz_o  = '0;
    found = 1'b0;
    for (int i = DW - 1; i >= 0; i--) begin
      if (!found && data_i[i]) begin
        lz_o  = LZW'(DW - 1 - i);
        found = 1'b1;
      end
    end
    all_zero_o = ~found;
  end

endmodule

// File: rtl/log2_approx_pipe.sv
// Multi-lane 3-stage log2 approximator: leading-one exponent plus linear mantissa,
// with valid/ready flow control, zero flag and aligned raw-input bypass.
module log2_approx_pipe
  import log2_approx_pkg::*;
#(
  parameter int LANES    = DEF_LANES,
  parameter int DW       = DEF_DW,
  parameter int IN_FRAC  = DEF_IN_FRAC,
  parameter int OUT_INT  = DEF_OUT_INT,
  parameter int OUT_FRAC = DEF_OUT_FRAC
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_en,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  input  logic [LANES*DW-1:0]                   i_data,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  output logic [LANES*(OUT_INT+OUT_FRAC)-1:0]   o_log2,
  output logic [LANES-1:0]                      o_zero,
  output logic [LANES*DW-1:0]                   o_byp
);

  localparam int OW      = OUT_INT + OUT_FRAC;
  localparam int LZW     = (DW > 1) ? $clog2(DW) : 1;
  localparam int INT_TOP = DW - 1 - IN_FRAC;
  localparam logic [OW-1:0] ZERO_RES = OW'(min_result(OW));

  if (OUT_FRAC > DW - 1) begin : g_bad_frac
    $fatal(1, "log2_approx_pipe: OUT_FRAC must not exceed DW-1");
  end
  if (OUT_INT < req_out_int(DW, IN_FRAC)) begin : g_bad_int
    $fatal(1, "log2_approx_pipe: OUT_INT too small for the exponent range");
  end

  logic                   adv;
  logic                   v0_q, v1_q, v2_q;
  logic [LANES*DW-1:0]    d0_q, d1_q, byp_q;
  logic [LANES*LZW-1:0]   lz1_q, lz_d;
  logic [LANES-1:0]       z1_q, z_d, zero_q;
  logic [LANES*OW-1:0]    log2_q, res_d;
  logic [LZW-1:0]         lz_k;
  logic [DW-1:0]          x_k;
  logic [OUT_INT-1:0]     int_k;
  logic [OUT_FRAC-1:0]    frac_k;

  // Whole pipe moves as one; a full output with no taker freezes everything.
  assign adv     = i_en & (~v2_q | i_ready);
  assign o_ready = adv;
  assign o_valid = v2_q;
  assign o_log2  = log2_q;
  assign o_zero  = zero_q;
  assign o_byp   = byp_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    log2_lzc #(.DW(DW), .LZW(LZW)) u_lzc (
      .data_i     (d0_q[k*DW +: DW]),
      .lz_o       (lz_d[k*LZW +: LZW]),
      .all_zero_o (z_d[k])
    );
  end

  // Normalising by lz puts the leading one at the MSB; the bits below it are the mantissa.
  always_comb begin
    res_d  = '0;
    lz_k   = '0;
    x_k    = '0;
    int_k  = '0;
    frac_k = '0;
    for (int k = 0; k < LANES; k++) begin
      lz_k   = lz1_q[k*LZW +: LZW];
      x_k    = d1_q[k*DW +: DW];
      int_k  = OUT_INT'(INT_TOP - int'(lz_k));
      frac_k = OUT_FRAC'((x_k << lz_k) >> (DW - 1 - OUT_FRAC));
      res_d[k*OW +: OW] = z1_q[k] ? ZERO_RES : {int_k, frac_k};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      d0_q   <= '0;
      d1_q   <= '0;
      lz1_q  <= '0;
      z1_q   <= '0;
      log2_q <= '0;
      zero_q <= '0;
      byp_q  <= '0;
    end else if (adv) begin
      v0_q   <= i_valid;
      d0_q   <= i_data;
      v1_q   <= v0_q;
      d1_q   <= d0_q;
      lz1_q  <= lz_d;
      z1_q   <= z_d;
      v2_q   <= v1_q;
      log2_q <= res_d;
      zero_q <= z1_q;
      byp_q  <= d1_q;
    end
  end

endmodule

// File: tb/tb_log2_approx_pipe.sv
// Self-checking bench for log2_approx_pipe: directed table, flow-control streams,
// randomized traffic and mid-stream reset against an arithmetic reference model.
module tb_log2_approx_pipe;

  localparam int LANES    = 2;
  localparam int DW       = 16;
  localparam int IN_FRAC  = 11;
  localparam int OUT_INT  = 6;
  localparam int OUT_FRAC = 10;
  localparam int OW       = OUT_INT + OUT_FRAC;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n;
  logic                  i_en;
  logic                  i_valid;
  logic                  o_ready;
  logic [LANES*DW-1:0]   i_data;
  logic                  o_valid;
  logic                  i_ready;
  logic [LANES*OW-1:0]   o_log2;
  logic [LANES-1:0]      o_zero;
  logic [LANES*DW-1:0]   o_byp;

  log2_approx_pipe #(
    .LANES(LANES), .DW(DW), .IN_FRAC(IN_FRAC), .OUT_INT(OUT_INT), .OUT_FRAC(OUT_FRAC)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_log2  (o_log2),
    .o_zero  (o_zero),
    .o_byp   (o_byp)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [LANES*OW-1:0] log2;
    logic [LANES-1:0]    zero;
    logic [LANES*DW-1:0] byp;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_push   = 0;
  int    n_pop    = 0;

  logic [15:0] tin  [7] = '{16'h0800, 16'h1000, 16'h0400, 16'h0C00, 16'hFFFF, 16'h0001, 16'h0000};
  logic [15:0] texp [7] = '{16'h0000, 16'h0400, 16'hFC00, 16'h0200, 16'h13FF, 16'hD400, 16'h8000};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: exponent = floor(log2 x), mantissa fraction = (x - 2^e) / 2^e truncated.
  function automatic beat_t model(input logic [LANES*DW-1:0] d);
    beat_t b;
    int x, e, r;
    b.byp  = d;
    b.log2 = '0;
    b.zero = '0;
    for (int k = 0; k < LANES; k++) begin
      x = int'(d[k*DW +: DW]);
      if (x == 0) begin
        r = 1 << (OW - 1);
        b.zero[k] = 1'b1;
      end else begin
        e = 0;
        while ((2 ** (e + 1)) <= x) e++;
        r = (e - IN_FRAC) * (2 ** OUT_FRAC) + ((x - 2 ** e) * (2 ** OUT_FRAC)) / (2 ** e);
      end
      b.log2[k*OW +: OW] = r[OW-1:0];
    end
    return b;
  endfunction

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      chk("o_ready_rule", o_ready, i_en & (~o_valid | i_ready));
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", o_valid, 1'b0);
        end else begin
          chk("out_log2", o_log2, exp_q[0].log2);
          chk("out_zero", o_zero, exp_q[0].zero);
          chk("out_byp",  o_byp,  exp_q[0].byp);
        end
      end
      if (o_valid && i_ready && i_en && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        n_pop++;
      end
      if (i_valid && o_ready) begin
        exp_q.push_back(model(i_data));
        n_push++;
      end
    end
  end

  task automatic stream(input int nb, input int st_s, input int st_l, input int en_s, input int en_l);
    logic [LANES*DW-1:0] beats[$];
    int  idx = 0;
    int  c   = 0;
    int  p0, q0;
    bit  acc;
    p0 = n_push;
    q0 = n_pop;
    for (int i = 0; i < nb; i++) beats.push_back($urandom);
    while ((idx < nb || exp_q.size() > 0) && c < 200) begin
      i_valid = (idx < nb);
      if (idx < nb) i_data = beats[idx];
      i_ready = !(c >= st_s && c < st_s + st_l);
      i_en    = !(c >= en_s && c < en_s + en_l);
      @(negedge i_clk);
      acc = i_valid & o_ready;
      if (!i_en) chk("en_low_ready", o_ready, 1'b0);
      if (o_valid && !i_ready) chk("stall_ready", o_ready, 1'b0);
      @(posedge i_clk);
      #1;
      if (acc) idx++;
      c++;
    end
    chk("stream_timeout", c < 200, 1'b1);
    chk("stream_accepted", n_push - p0, nb);
    chk("stream_delivered", n_pop - q0, nb);
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_en    = 1'b1;
  endtask

  initial begin
    int j;
    logic [15:0] l0, l1;
    i_rst_n = 1'b0;
    i_en    = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_data  = '0;
    repeat (2) @(negedge i_clk);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_log2",  o_log2,  '0);
    chk("rst_zero",  o_zero,  '0);
    chk("rst_byp",   o_byp,   '0);
    #2 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Directed table: lane 1 carries the next table entry, so each lane sees different data.
    for (int i = 0; i < 7; i++) begin
      j = (i + 1) % 7;
      i_data  = {tin[j], tin[i]};
      i_valid = 1'b1;
      @(negedge i_clk);
      chk("dir_ready", o_ready, 1'b1);
      @(posedge i_clk);
      #1 i_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        @(negedge i_clk);
        chk("dir_latency", o_valid, (k == 3));
      end
      chk("dir_lane0", o_log2[15:0],  texp[i]);
      chk("dir_lane1", o_log2[31:16], texp[j]);
      chk("dir_zero",  o_zero, {tin[j] == 16'h0, tin[i] == 16'h0});
      chk("dir_byp",   o_byp,  {tin[j], tin[i]});
      @(posedge i_clk);
      #1;
    end

    stream(6, 4, 5, 999, 0);
    stream(8, 999, 0, 3, 3);
    stream(10, 2, 3, 6, 2);

    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < LANES; k++) begin
        case ($urandom_range(0, 5))
          0:       i_data[k*DW +: DW] = '0;
          1:       i_data[k*DW +: DW] = DW'(1) << $urandom_range(0, DW - 1);
          2:       i_data[k*DW +: DW] = '1;
          default: i_data[k*DW +: DW] = DW'($urandom);
        endcase
      end
      i_valid = ($urandom_range(0, 9) < 7);
      i_ready = ($urandom_range(0, 3) != 0);
      i_en    = ($urandom_range(0, 19) > 2);
      @(negedge i_clk);
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_en    = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      @(posedge i_clk);
      #1;
    end
    chk("random_drain", exp_q.size(), 0);

    // Three beats in flight, then reset between edges.
    for (int i = 0; i < 3; i++) begin
      l0 = 16'($urandom) | 16'h0100;
      l1 = 16'($urandom) | 16'h0100;
      i_data  = {l1, l0};
      i_valid = 1'b1;
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
    chk("pre_reset_valid", o_valid, 1'b1);
    #1 i_rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_valid", o_valid, 1'b0);
    chk("async_rst_log2",  o_log2,  '0);
    chk("async_rst_byp",   o_byp,   '0);
    @(negedge i_clk);
    #2 i_rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      chk("post_reset_valid", o_valid, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/log2_approx_pipe.md
Name: log2_approx_pipe

Overview:
Parametrised multi-lane base-2 logarithm approximator for the softmax-with-tree datapath. Each lane takes an unsigned fixed-point value and produces a signed fixed-point log2: the integer part comes from the leading-one position, and the fractional part is the linear mantissa approximation (log2(1+m) ≈ m). The block adds valid/ready backpressure, a zero-input flag and an aligned raw-input bypass.

Parameters:
LANES, 2, number of independent lanes processed in lock-step
DW, 16, input data width per lane (unsigned)
IN_FRAC, 11, fractional bits of the input (input format is Q(DW-IN_FRAC).IN_FRAC)
OUT_INT, 6, signed integer bits of the output, including sign
OUT_FRAC, 10, fractional bits of the output; OUT_FRAC <= DW-1
OW, OUT_INT+OUT_FRAC, derived output width per lane (localparam)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_en  in  1  global clock enable; when low, all state holds
i_valid  in  1  input beat valid
o_ready  out  1  block can accept an input beat
i_data  in  LANES*DW  lane k occupies bits [k*DW +: DW]
o_valid  out  1  output beat valid
i_ready  in  1  downstream accepts the output beat
o_log2  out  LANES*OW  lane k log2 in Q(OUT_INT).OUT_FRAC two's complement
o_zero  out  LANES  lane k input was exactly zero
o_byp  out  LANES*DW  raw i_data aligned with o_log2

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0 and all data registers = 0. o_valid=0, o_log2=0, o_zero=0, o_byp=0.
- Pipeline: 3 registered stages. S0 registers the input. S1 registers the leading-zero count lz per lane. S2 registers the result. Latency is exactly 3 cycles from accepted beat to o_valid with no stall.
- Advance: adv = i_en & (~o_valid | i_ready). All stages shift together only when adv=1; otherwise every stage holds, including valid bits. Bubbles are not compressed.
- o_ready = adv (combinational). An input is accepted when i_valid & o_ready.
- An output is consumed when o_valid & i_ready & i_en. o_valid and o_log2/o_zero/o_byp stay stable while o_valid=1 and the beat is not consumed.
- i_en=0 with i_ready=1 does not consume the beat.
- If an input valid=0 is accepted, it propagates as a bubble. Data registers may still load but are don't-care.
- Per lane, with x the DW-bit input:
  - lz = number of leading zeros, range 0..DW-1. For x=0, lz is don't-care and zero=1.
  - int = (DW-1-IN_FRAC) - lz, sign-extended/truncated to OUT_INT bits.
  - norm = x << lz, DW bits. frac = norm[DW-2 -: OUT_FRAC].
  - o_log2 = {int, frac}.
  - If x=0: o_log2 = most negative value (1 followed by OW-1 zeros), o_zero=1.
  - MSB set (lz=0) is a normal case: int = DW-1-IN_FRAC.
- Lanes are fully independent. o_zero is per lane.
- Elaboration check (fatal): OUT_FRAC <= DW-1, and OUT_INT is large enough to hold both DW-1-IN_FRAC and -IN_FRAC.
- Reset mid-stream: all in-flight beats are discarded, and o_valid drops asynchronously.

Decomposition:
- Package log2_approx_pkg holds:
  - default widths;
  - a function computing the required OUT_INT;
  - the zero-result constant generator (most negative OW value).
- Sub-module log2_lzc:
  - parametrised DW-bit leading-zero counter, combinational;
  - outputs lz[$clog2(DW)-1:0] and all_zero;
  - instantiated LANES times between S0 and S1.

Test Plan:
(Defaults, lane 0 shown; lane 1 driven with different values each time to check lane independence.)
- Exact powers of two: i_data=0x0800 -> o_log2=0x0000. 0x1000 -> 0x0400. 0x0400 -> 0xFC00. Each appears exactly 3 cycles after acceptance, o_zero=0.
- Mantissa and extremes: 0x0C00 -> 0x0200. 0xFFFF -> 0x13FF (lz=0 case). 0x0001 -> 0xD400.
- Zero input: 0x0000 -> o_log2=0x8000, o_zero[0]=1, o_byp lane0=0x0000. Simultaneously lane1=0x0800 -> 0x0000, o_zero[1]=0.
- Backpressure: stream 6 back-to-back beats while holding i_ready=0 from cycle 4 for 5 cycles -> o_ready=0 while o_valid=1 and i_ready=0; output held stable; no beat lost or duplicated; order preserved.
- i_en gating: drop i_en for 3 cycles mid-stream with i_ready=1 -> no state change, o_ready=0, output beat not consumed; resumes identically once i_en=1.
- Async reset: assert i_rst_n=0 between clock edges with 3 beats in flight -> o_valid=0 immediately; after release no stale beat ever appears.
